// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single cache port: instruction fetch
// (port 0, read-only) and data (port 1, read/write), with a BUSY wait timeout.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: instruction fetch
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  // port 1: data memory
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  // cache side
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          err,
  output logic          grant,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester holds req until it sees its ack (one-cycle pulse),
  // then drops req; any req still high once the FSM is back in IDLE is a new request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          r_en_q, r_en_d;
  logic          w_en_q, w_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          err_q, err_d;
  logic [7:0]    wait_q, wait_d;
  logic          win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b1;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      r_en_q   <= r_en_d;
      w_en_q   <= w_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  // On a tie the port that did not win last time goes next.
  always_comb begin
    win = (req0 && req1) ? ~grant_q : req1;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    r_en_d   = r_en_q;
    w_en_d   = w_en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    wait_d   = wait_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d = win;
          addr_d  = win ? addr1 : addr0;
          if (win) begin
            wdata_d = wdata1;
          end
          w_en_d  = win & we1;
          r_en_d  = ~(win & we1);
          wait_d  = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          if (r_en_q) begin
            if (grant_q) begin
              rdata1_d = mem_rdata;
            end else begin
              rdata0_d = mem_rdata;
            end
          end
          r_en_d  = 1'b0;
          w_en_d  = 1'b0;
          state_d = S_RESP;
        end else if (wait_q == TO_LAST) begin
          // Abort: report through the sticky flag, leave rdata untouched.
          err_d   = 1'b1;
          r_en_d  = 1'b0;
          w_en_d  = 1'b0;
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack0      = (state_q == S_RESP) && !grant_q;
  assign ack1      = (state_q == S_RESP) && grant_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_r_en  = r_en_q;
  assign mem_w_en  = w_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign grant     = grant_q;
  assign dbg_state = state_q;

endmodule
